// File: rtl/mux16_scan_seq.sv
// Scan sequencer for a 16:1 bit mux: steps Sel through all codes, samples Y_in per code,
// and presents the assembled word with a one-cycle valid pulse. Optional parity via MUX16_SCAN_PARITY_EN.
module mux16_scan_seq #(
  parameter bit DIR = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        cont,
  input  logic        stop,
  input  logic        Y_in,
  output logic [3:0]  Sel,
  output logic [15:0] Dados_out,
  output logic        valid,
  output logic        busy
`ifdef MUX16_SCAN_PARITY_EN
  ,
  output logic        Paridade
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  localparam logic [3:0] FIRST_SEL = DIR ? 4'hF : 4'h0;

  state_e      state_q, state_d;
  logic [3:0]  sel_q, sel_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] shadow_q, shadow_d;
  logic [15:0] dados_q, dados_d;
  logic        valid_q, valid_d;
  logic [15:0] word_full;
`ifdef MUX16_SCAN_PARITY_EN
  logic        par_q, par_d;
`endif

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    dados_d   = dados_q;
    valid_d   = 1'b0;
`ifdef MUX16_SCAN_PARITY_EN
    par_d     = par_q;
`endif
    // Shadow word with the bit currently presented on the mux merged in.
    word_full        = shadow_q;
    word_full[sel_q] = Y_in;

    case (state_q)
      IDLE: begin
        sel_d = FIRST_SEL;
        if (start) begin
          state_d  = SCAN;
          cnt_d    = 4'd0;
          shadow_d = 16'h0000;
        end
      end
      SCAN: begin
        // Abort wins even on the cycle the final bit would have been captured.
        if (stop) begin
          state_d  = IDLE;
          sel_d    = FIRST_SEL;
          cnt_d    = 4'd0;
          shadow_d = 16'h0000;
        end else if (cnt_q == 4'd15) begin
          state_d  = DONE;
          sel_d    = FIRST_SEL;
          cnt_d    = 4'd0;
          shadow_d = word_full;
          dados_d  = word_full;
          valid_d  = 1'b1;
`ifdef MUX16_SCAN_PARITY_EN
          par_d    = ^word_full;
`endif
        end else begin
          cnt_d    = cnt_q + 4'd1;
          shadow_d = word_full;
          sel_d    = DIR ? (sel_q - 4'd1) : (sel_q + 4'd1);
        end
      end
      DONE: begin
        sel_d    = FIRST_SEL;
        cnt_d    = 4'd0;
        shadow_d = 16'h0000;
        state_d  = cont ? SCAN : IDLE;
      end
      default: begin
        state_d = IDLE;
        sel_d   = FIRST_SEL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= FIRST_SEL;
      cnt_q    <= 4'd0;
      shadow_q <= 16'h0000;
      dados_q  <= 16'h0000;
      valid_q  <= 1'b0;
`ifdef MUX16_SCAN_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      dados_q  <= dados_d;
      valid_q  <= valid_d;
`ifdef MUX16_SCAN_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign Sel       = sel_q;
  assign Dados_out = dados_q;
  assign valid     = valid_q;
  assign busy      = (state_q == SCAN);
`ifdef MUX16_SCAN_PARITY_EN
  assign Paridade  = par_q;
`endif

endmodule

// File: tb/tb_mux16_scan_seq.sv
// Bench for mux16_scan_seq: one ascending and one descending instance, each fed by a modelled mux,
// compared every cycle against a scan-position model plus literal checks of the scenarios.
module tb_mux16_scan_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i [2];
  logic        cont_i  [2];
  logic        stop_i  [2];
  logic [15:0] word    [2];
  logic        y_i     [2];
  logic [3:0]  sel_o   [2];
  logic [15:0] dados_o [2];
  logic        valid_o [2];
  logic        busy_o  [2];
`ifdef MUX16_SCAN_PARITY_EN
  logic        par_o   [2];
`endif

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  assign y_i[0] = word[0][sel_o[0]];
  assign y_i[1] = word[1][sel_o[1]];

  mux16_scan_seq #(.DIR(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start_i[0]), .cont(cont_i[0]), .stop(stop_i[0]),
    .Y_in(y_i[0]), .Sel(sel_o[0]), .Dados_out(dados_o[0]), .valid(valid_o[0]), .busy(busy_o[0])
`ifdef MUX16_SCAN_PARITY_EN
    , .Paridade(par_o[0])
`endif
  );

  mux16_scan_seq #(.DIR(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start_i[1]), .cont(cont_i[1]), .stop(stop_i[1]),
    .Y_in(y_i[1]), .Sel(sel_o[1]), .Dados_out(dados_o[1]), .valid(valid_o[1]), .busy(busy_o[1])
`ifdef MUX16_SCAN_PARITY_EN
    , .Paridade(par_o[1])
`endif
  );

  // Model: ph = -1 idle, 0..15 position in the scan, 16 the word-complete cycle.
  int          ph    [2] = '{-1, -1};
  logic [15:0] m_shw [2] = '{16'h0, 16'h0};
  logic [15:0] m_dat [2] = '{16'h0, 16'h0};
  logic        m_vld [2] = '{1'b0, 1'b0};
  logic        m_par [2] = '{1'b0, 1'b0};

  function automatic int pos_sel(input int d, input int p);
    if (p >= 0 && p <= 15) return (d == 1) ? 15 - p : p;
    return (d == 1) ? 15 : 0;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 2; d++) begin
      int          p;
      logic [15:0] s;
      logic [15:0] dt;
      logic        v;
      logic        pr;
      p = ph[d]; s = m_shw[d]; dt = m_dat[d]; v = 1'b0; pr = m_par[d];
      if (rst) begin
        p = -1; s = 16'h0; dt = 16'h0; pr = 1'b0;
      end else if (p < 0) begin
        if (start_i[d]) begin p = 0; s = 16'h0; end
      end else if (p == 16) begin
        p = cont_i[d] ? 0 : -1;
        s = 16'h0;
      end else if (stop_i[d]) begin
        p = -1; s = 16'h0;
      end else begin
        s[pos_sel(d, p)] = word[d][pos_sel(d, p)];
        if (p == 15) begin
          dt = s; v = 1'b1; pr = ^s; p = 16;
        end else begin
          p = p + 1;
        end
      end
      ph[d] <= p; m_shw[d] <= s; m_dat[d] <= dt; m_vld[d] <= v; m_par[d] <= pr;
    end
  end

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] actual=%h required=%h at cycle %0d", nm, d, act, exp, cyc);
    end
  endtask

  // One cycle: wait for the inactive edge, then compare every output against the model.
  task automatic tick();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("sel",   d, 32'(sel_o[d]),   32'(pos_sel(d, ph[d])));
      chk("busy",  d, 32'(busy_o[d]),  32'(ph[d] >= 0 && ph[d] <= 15));
      chk("valid", d, 32'(valid_o[d]), 32'(m_vld[d]));
      chk("dados", d, 32'(dados_o[d]), 32'(m_dat[d]));
`ifdef MUX16_SCAN_PARITY_EN
      chk("parity", d, 32'(par_o[d]), 32'(m_par[d]));
`endif
    end
  endtask

  task automatic pulse_start(input int d, output int t0);
    start_i[d] = 1'b1;
    t0 = cyc;
    tick();
    start_i[d] = 1'b0;
  endtask

  task automatic wait_valid(input int d);
    for (int i = 0; i < 60; i++) begin
      tick();
      if (valid_o[d]) return;
    end
    chk("wait_valid_timeout", d, 0, 1);
  endtask

  task automatic wait_sel(input int d, input logic [3:0] v);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy_o[d] && sel_o[d] == v) return;
    end
    chk("wait_sel_timeout", d, 0, 1);
  endtask

  initial begin
    int t0;
    int nv;
    for (int d = 0; d < 2; d++) begin
      start_i[d] = 1'b0; cont_i[d] = 1'b0; stop_i[d] = 1'b0; word[d] = 16'h0;
    end
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_sel", 0, 32'(sel_o[0]), 32'h0);
    chk("rst_sel", 1, 32'(sel_o[1]), 32'hF);
    chk("rst_dados", 0, 32'(dados_o[0]), 32'h0);
    chk("rst_valid_busy", 0, {valid_o[0], busy_o[0]}, 0);
    rst = 1'b0;
    tick();

    // Ascending scan
    word[0] = 16'hA5C3;
    pulse_start(0, t0);
    chk("asc_first_sel", 0, 32'(sel_o[0]), 32'h0);
    chk("asc_busy", 0, 32'(busy_o[0]), 1);
    wait_valid(0);
    chk("asc_latency", 0, cyc - t0, 17);
    chk("asc_word", 0, 32'(dados_o[0]), 32'hA5C3);
    chk("asc_busy_done", 0, 32'(busy_o[0]), 0);
    tick();
    chk("asc_valid_drop", 0, 32'(valid_o[0]), 0);

    // Descending scan: bit order follows Sel, not time
    word[1] = 16'h8001;
    pulse_start(1, t0);
    chk("desc_first_sel", 1, 32'(sel_o[1]), 32'hF);
    tick();
    chk("desc_second_sel", 1, 32'(sel_o[1]), 32'hE);
    wait_valid(1);
    chk("desc_latency", 1, cyc - t0, 17);
    chk("desc_word", 1, 32'(dados_o[1]), 32'h8001);
    tick();

    // Abort after Sel=6 is presented
    word[0] = 16'h5555;
    pulse_start(0, t0);
    wait_sel(0, 4'd6);
    stop_i[0] = 1'b1;
    tick();
    stop_i[0] = 1'b0;
    chk("abort_sel", 0, 32'(sel_o[0]), 32'h0);
    chk("abort_busy", 0, 32'(busy_o[0]), 0);
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (valid_o[0]) nv++;
    end
    chk("abort_novalid", 0, nv, 0);
    chk("abort_keep", 0, 32'(dados_o[0]), 32'hA5C3);

    // Continuous mode, start held high throughout
    word[0] = 16'h1234;
    cont_i[0] = 1'b1;
    start_i[0] = 1'b1;
    t0 = cyc;
    wait_valid(0);
    chk("cont_latency", 0, cyc - t0, 17);
    chk("cont_word1", 0, 32'(dados_o[0]), 32'h1234);
    word[0] = 16'hFFFF;
    t0 = cyc;
    wait_valid(0);
    chk("cont_period", 0, cyc - t0, 17);
    chk("cont_word2", 0, 32'(dados_o[0]), 32'hFFFF);
    cont_i[0] = 1'b0;
    start_i[0] = 1'b0;
    tick();
    tick();
    chk("cont_idle", 0, 32'(busy_o[0]), 0);

    // Reset mid-scan
    pulse_start(0, t0);
    wait_sel(0, 4'd9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_sel", 0, 32'(sel_o[0]), 32'h0);
    chk("rstmid_dados", 0, 32'(dados_o[0]), 32'h0);
    chk("rstmid_vb", 0, {valid_o[0], busy_o[0]}, 0);

    // Full scans after reset, with parity words
    word[0] = 16'h0007;
    pulse_start(0, t0);
    wait_valid(0);
    chk("post_rst_latency", 0, cyc - t0, 17);
    chk("word_0007", 0, 32'(dados_o[0]), 32'h0007);
`ifdef MUX16_SCAN_PARITY_EN
    chk("parity_0007", 0, 32'(par_o[0]), 1);
`endif
    tick();
    word[0] = 16'h0003;
    pulse_start(0, t0);
    wait_valid(0);
    chk("word_0003", 0, 32'(dados_o[0]), 32'h0003);
`ifdef MUX16_SCAN_PARITY_EN
    chk("parity_0003", 0, 32'(par_o[0]), 0);
`endif
    tick();

    // Randomized traffic on both instances
    for (int i = 0; i < 2000; i++) begin
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(0, 19) == 0) word[d] = 16'($urandom);
        start_i[d] = ($urandom_range(0, 7) == 0);
        stop_i[d]  = ($urandom_range(0, 39) == 0);
        cont_i[d]  = ($urandom_range(0, 2) == 0);
      end
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start_i[d] = 1'b0; stop_i[d] = 1'b0; cont_i[d] = 1'b0;
    end
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
